// File: rtl/alu_result_sink.sv
// alu_result_sink: consumer end of the ALU/shifter interface.
// Buffers register writebacks in a small first-word fall-through FIFO, keeps the
// architectural S/Z/C/V register and resolves branches against forwarded flags.
module alu_result_sink #(
  parameter int DEPTH  = 2,
  parameter int RWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [15:0]       in_res,
  input  logic [3:0]        in_szcv,
  input  logic [RWIDTH-1:0] in_rd,
  input  logic              in_setf,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RWIDTH-1:0] wb_addr,
  output logic [15:0]       wb_data,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  output logic              br_done,
  output logic              br_taken,
  output logic [3:0]        flags
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0101;

  logic [RWIDTH+15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [AW:0]        count_next;
  logic               is_cmp;
  logic               full;
  logic               pop;
  logic               accept;
  logic               push;
  logic [3:0]         flags_next;
  logic               cond_taken;
  logic [RWIDTH+15:0] head;

  assign is_cmp   = (in_op == OP_CMP);
  assign full     = (count == FULL_CNT);
  assign wb_valid = (count != '0);
  assign pop      = wb_valid & wb_ready;
  // CMP never occupies a slot, so it is always accepted.
  assign in_ready = is_cmp | ~full | pop;
  assign accept   = in_valid & in_ready;
  assign push     = accept & ~is_cmp;

  // Outputs read as zero whenever the FIFO is empty (including after reset).
  assign head    = mem[rd_ptr];
  assign wb_addr = wb_valid ? head[RWIDTH+15:16] : '0;
  assign wb_data = wb_valid ? head[15:0] : '0;

  // Occupancy update from independent push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW + 1)'(1);
      2'b01:   count_next = count - (AW + 1)'(1);
      default: count_next = count;
    endcase
  end

  // Flag value after this cycle's accept; V is only meaningful for ADD/SUB.
  always_comb begin
    flags_next = flags;
    if (accept && in_setf) begin
      flags_next[3:1] = in_szcv[3:1];
      flags_next[0]   = ((in_op == OP_ADD) || (in_op == OP_SUB)) ? in_szcv[0] : 1'b0;
    end
  end

  // Branch condition evaluated on the forwarded flags.
  always_comb begin
    cond_taken = 1'b0;
    case (br_cond)
      3'b000:  cond_taken = flags_next[2];
      3'b001:  cond_taken = flags_next[3] ^ flags_next[0];
      3'b010:  cond_taken = flags_next[2] | (flags_next[3] ^ flags_next[0]);
      3'b011:  cond_taken = ~flags_next[2];
      3'b100:  cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // FIFO storage; a full-FIFO push with a pop overwrites the slot being consumed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_rd, in_res};
  end

  // Pointers, occupancy, flag register and branch result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      flags    <= '0;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      flags    <= flags_next;
      br_done  <= br_req;
      br_taken <= br_req & cond_taken;
    end
  end

endmodule

// File: tb/tb_alu_result_sink.sv
// Scoreboard bench for alu_result_sink: stimulus queues expected writebacks and
// branch decisions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_alu_result_sink;

  localparam int RW = 3;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [15:0]   in_res;
  logic [3:0]    in_szcv;
  logic [RW-1:0] in_rd;
  logic          in_setf;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_addr;
  logic [15:0]   wb_data;
  logic          br_req;
  logic [2:0]    br_cond;
  logic          br_done;
  logic          br_taken;
  logic [3:0]    flags;

  int checks = 0;
  int errors = 0;

  logic [RW+15:0] wbq[$];
  logic           bq[$];

  alu_result_sink #(.DEPTH(2), .RWIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_res(in_res),
    .in_szcv(in_szcv), .in_rd(in_rd), .in_setf(in_setf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_req(br_req), .br_cond(br_cond), .br_done(br_done), .br_taken(br_taken),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic [RW-1:0] rd,
                       input logic [3:0] szcv, input logic setf);
    in_valid = 1'b1;
    in_op    = op;
    in_res   = res;
    in_rd    = rd;
    in_szcv  = szcv;
    in_setf  = setf;
  endtask

  // Present one result and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] op, input logic [15:0] res, input logic [RW-1:0] rd,
                      input logic [3:0] szcv, input logic setf);
    bit ok = 1'b0;
    drive(op, res, rd, szcv, setf);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (op != OP_CMP) wbq.push_back({rd, res});
      end
      step();
    end
    in_valid = 1'b0;
    chk("send_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Writeback and branch-result monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid && wb_ready) begin
        checks++;
        if (wbq.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got addr %0h data %0h expected none", wb_addr, wb_data);
        end else begin
          logic [RW+15:0] e;
          e = wbq.pop_front();
          if ({wb_addr, wb_data} !== e) begin
            errors++;
            $display("FAIL wb_entry: got %0h expected %0h", {wb_addr, wb_data}, e);
          end
        end
      end
      if (br_done) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL br_unexpected: got br_done=1 expected 0");
        end else begin
          logic t;
          t = bq.pop_front();
          if (br_taken !== t) begin
            errors++;
            $display("FAIL br_taken: got %0b expected %0b", br_taken, t);
          end
        end
      end
    end
  end

  initial begin
    logic exp_taken [8];
    exp_taken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_res = '0; in_szcv = '0; in_rd = '0;
    in_setf = 1'b0; wb_ready = 1'b0; br_req = 1'b0; br_cond = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_br_done", {31'd0, br_done}, 32'd0);

    // Single ADD: no bypass in the accept cycle, visible one cycle later.
    step();
    wb_ready = 1'b1;
    drive(OP_ADD, 16'h0005, 3'd3, 4'b0000, 1'b0);
    @(negedge clk);
    chk("no_bypass", {31'd0, wb_valid}, 32'd0);
    wbq.push_back({3'd3, 16'h0005});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_wb_addr", {29'd0, wb_addr}, 32'd3);
    chk("add_wb_data", {16'd0, wb_data}, 32'h0005);
    step();
    @(negedge clk);
    chk("add_drained", {31'd0, wb_valid}, 32'd0);

    // Fill with wb_ready=0, CMP still accepted while full.
    step();
    wb_ready = 1'b0;
    send(OP_MOV, 16'h0001, 3'd1, 4'b0000, 1'b0);
    send(OP_MOV, 16'h0002, 3'd2, 4'b0000, 1'b0);
    drive(OP_CMP, 16'hFFFF, 3'd7, 4'b0100, 1'b1);
    @(negedge clk);
    chk("cmp_ready_full", {31'd0, in_ready}, 32'd1);
    step();
    drive(OP_MOV, 16'h0003, 3'd4, 4'b0000, 1'b0);
    @(negedge clk);
    chk("cmp_flags", {28'd0, flags}, 32'b0100);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_stable", {13'd0, wb_addr, wb_data}, {13'd0, 3'd1, 16'h0001});
    step();
    wb_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_push_ready", {31'd0, in_ready}, 32'd1);
    wbq.push_back({3'd4, 16'h0003});
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // SUB with same-cycle BLT: forwarded S=1,V=1 -> not taken.
    drive(OP_SUB, 16'h1234, 3'd5, 4'b1001, 1'b1);
    br_req = 1'b1; br_cond = 3'b001;
    wbq.push_back({3'd5, 16'h1234}); bq.push_back(1'b0);
    step();
    in_valid = 1'b0; br_req = 1'b0;
    @(negedge clk);
    chk("sub_flags", {28'd0, flags}, 32'b1001);
    step();
    // XOR discards V: flags 1000, BLT taken.
    drive(OP_XOR, 16'h00FF, 3'd6, 4'b1001, 1'b1);
    br_req = 1'b1; br_cond = 3'b001;
    wbq.push_back({3'd6, 16'h00FF}); bq.push_back(1'b1);
    step();
    in_valid = 1'b0; br_req = 1'b0;
    @(negedge clk);
    chk("xor_flags", {28'd0, flags}, 32'b1000);
    step();

    // Z only, sweep all condition codes; setf=0 result leaves flags alone.
    send(OP_CMP, 16'h0000, 3'd0, 4'b0100, 1'b1);
    send(OP_MOV, 16'h00AA, 3'd2, 4'b1011, 1'b0);
    @(negedge clk);
    chk("setf0_flags", {28'd0, flags}, 32'b0100);
    step();
    for (int c = 0; c < 8; c++) begin
      br_req = 1'b1; br_cond = 3'(c);
      bq.push_back(exp_taken[c]);
      step();
    end
    br_req = 1'b0;
    repeat (3) step();

    // Reset with buffered entries and a pending branch: everything dropped.
    wb_ready = 1'b0;
    send(OP_MOV, 16'h0BAD, 3'd1, 4'b0000, 1'b0);
    send(OP_MOV, 16'h0DAD, 3'd2, 4'b0000, 1'b0);
    rst = 1'b1; br_req = 1'b1; br_cond = 3'b100;
    wbq.delete();
    step();
    rst = 1'b0; br_req = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("rst2_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst2_flags", {28'd0, flags}, 32'd0);
    chk("rst2_br_done", {31'd0, br_done}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) step();

    chk("wbq_empty", wbq.size(), 32'd0);
    chk("bq_empty", bq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
